// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : burst_mem_responder
// Purpose  : Line-oriented memory target. A read or write request selects
//            one 256-bit line, waits LATENCY cycles, then moves the line as
//            four 64-bit beats strobed by resp_o. Protocol misuse raises a
//            sticky err_o that only reset clears.
// Revision : 1.0 - initial release
// ============================================================================
module burst_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(NUM_LINES);

  // The WAIT state covers LATENCY-1 cycles; its counter counts down to zero,
  // so it is loaded with LATENCY-2. LATENCY=1 skips WAIT entirely.
  localparam logic [3:0] C_WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic       C_SKIP_WAIT = (LATENCY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RBURST = 3'd2,
    S_WBURST = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_is_write;
  logic [3:0]         r_cnt;
  logic [1:0]         r_beat;
  logic               r_err;
  logic [255:0]       r_mem [NUM_LINES];

  logic               w_accept;
  logic               w_both;
  logic               w_in_txn;
  logic               w_req_held;
  logic [IDX_W-1:0]   w_addr_idx;
  logic               w_unused;

  // Only the line-index field of the address is meaningful; the rest aliases.
  assign w_addr_idx = address_i[5 +: IDX_W];
  assign w_unused   = ^{address_i[31:5+IDX_W], address_i[4:0]};

  assign w_both     = read_i & write_i;
  assign w_accept   = (r_state == S_IDLE) & (read_i ^ write_i);
  assign w_in_txn   = (r_state == S_WAIT) | (r_state == S_RBURST) | (r_state == S_WBURST);
  assign w_req_held = r_is_write ? write_i : read_i;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (C_SKIP_WAIT) begin
            w_next_state = write_i ? S_WBURST : S_RBURST;
          end else begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = r_is_write ? S_WBURST : S_RBURST;
        end
      end
      S_RBURST, S_WBURST: begin
        if (r_beat == 2'd3) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transaction context: latched index/direction, latency and beat counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_cnt      <= 4'd0;
      r_beat     <= 2'd0;
    end else begin
      if (w_accept) begin
        r_idx      <= w_addr_idx;
        r_is_write <= write_i;
        r_cnt      <= C_WAIT_LOAD;
        r_beat     <= 2'd0;
      end else if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end
      end else if ((r_state == S_RBURST) || (r_state == S_WBURST)) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  // Sticky error: conflicting request in IDLE, or request dropped mid-transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (((r_state == S_IDLE) && w_both) || (w_in_txn && !w_req_held)) begin
      r_err <= 1'b1;
    end
  end

  // Line storage: cleared by reset, one 64-bit beat written per WBURST cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == S_WBURST) begin
      r_mem[r_idx][{r_beat, 6'd0} +: 64] <= burst_i;
    end
  end

  assign resp_o  = (r_state == S_RBURST) | (r_state == S_WBURST);
  assign burst_o = (r_state == S_RBURST) ? r_mem[r_idx][{r_beat, 6'd0} +: 64] : 64'd0;
  assign err_o   = r_err;

endmodule
`default_nettype wire
